// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - single-transfer Wishbone classic master driven by a CPU load/store port
//
// Purpose: accepts one CPU request at a time, runs it as a Wishbone classic
// cycle and returns a one-cycle completion pulse with read data or an error.
// Optional bus watchdog: define WB_TIMEOUT_EN to abort cycles after TIMEOUT
// BUS cycles without termination.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            CPU request handshake
//   req_we/adr/data/sel            CPU request fields
//   resp_valid/resp_data/resp_err  completion pulse and result
//   adr_out/data_out/we_out/sel_out/stb_out/cyc_out  Wishbone master outputs
//   data_in/akn_in/err_in          Wishbone slave return path
module wb_master_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] adr_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              we_out,
  output logic [SEL_W-1:0]  sel_out,
  output logic              stb_out,
  output logic              cyc_out,
  input  logic              akn_in,
  input  logic              err_in
);

  if (TIMEOUT < 1 || (DATA_W % 8) != 0) begin : g_bad_param
    $error("wb_master_bridge: TIMEOUT must be >= 1 and DATA_W a multiple of 8");
  end

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  // cnt_q counts completed BUS cycles; this edge brings it to TIMEOUT.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    sel_d        = sel_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
`ifdef WB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          adr_d   = req_adr;
          wdata_d = req_data;
          we_d    = req_we;
          sel_d   = req_sel;
          state_d = BUS;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
`ifdef WB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // err_in outranks akn_in; both outrank the watchdog.
        if (err_in) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end else if (akn_in) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = we_q ? '0 : data_in;
        end
`ifdef WB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
`ifdef WB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Strobe/cycle come straight off the state flop so reset drops them at once.
  assign stb_out    = (state_q == BUS);
  assign cyc_out    = (state_q == BUS);
  assign req_ready  = (state_q == IDLE);
  assign adr_out    = adr_q;
  assign data_out   = wdata_q;
  assign we_out     = we_q;
  assign sel_out    = sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - self-checking bench for wb_master_bridge
module tb_wb_master_bridge;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_adr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic [SEL_W-1:0]  req_sel = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [ADDR_W-1:0] adr_out;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in = '0;
  logic              we_out;
  logic [SEL_W-1:0]  sel_out;
  logic              stb_out;
  logic              cyc_out;
  logic              akn_in = 1'b0;
  logic              err_in = 1'b0;

  wb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_data(req_data), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .adr_out(adr_out), .data_out(data_out), .data_in(data_in),
    .we_out(we_out), .sel_out(sel_out), .stb_out(stb_out), .cyc_out(cyc_out),
    .akn_in(akn_in), .err_in(err_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, its age in bus
  // cycles, and the last completion result.
  bit              m_busy;
  int              m_age;
  logic            m_we;
  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_data;
  logic [SEL_W-1:0]  m_sel;
  bit              m_rv;
  bit              m_re;
  logic [DATA_W-1:0] m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_we = 0; m_adr = '0; m_data = '0; m_sel = '0;
      m_rv = 0; m_re = 0; m_rd = '0;
    end else begin
      m_rv = 0;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_age = 0;
          m_we = req_we; m_adr = req_adr; m_data = req_data; m_sel = req_sel;
        end
      end else begin
        m_age = m_age + 1;
        if (err_in) begin
          m_busy = 0; m_rv = 1; m_re = 1; m_rd = '0;
        end else if (akn_in) begin
          m_busy = 0; m_rv = 1; m_re = 0; m_rd = m_we ? '0 : data_in;
        end
`ifdef WB_TIMEOUT_EN
        else if (m_age == TIMEOUT) begin
          m_busy = 0; m_rv = 1; m_re = 1; m_rd = '0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("stb_out",    32'(stb_out),    32'(m_busy));
      check("cyc_out",    32'(cyc_out),    32'(m_busy));
      check("req_ready",  32'(req_ready),  32'(!m_busy));
      check("we_out",     32'(we_out),     32'(m_we));
      check("adr_out",    32'(adr_out),    32'(m_adr));
      check("data_out",   32'(data_out),   32'(m_data));
      check("sel_out",    32'(sel_out),    32'(m_sel));
      check("resp_valid", 32'(resp_valid), 32'(m_rv));
      check("resp_err",   32'(resp_err),   32'(m_re));
      check("resp_data",  32'(resp_data),  32'(m_rd));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic we, input logic [15:0] adr,
                           input logic [15:0] dat, input logic [1:0] sel);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_data = dat; req_sel = sel;
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    step(); step();
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_resp_data",  32'(resp_data),  32'd0);
    check("rst_stb",        32'(stb_out),    32'd0);
    check("rst_cyc",        32'(cyc_out),    32'd0);
    check("rst_we",         32'(we_out),     32'd0);
    check("rst_adr",        32'(adr_out),    32'd0);
    check("rst_data",       32'(data_out),   32'd0);
    check("rst_sel",        32'(sel_out),    32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Zero-wait write
    drive_req(1'b1, 16'h0010, 16'hBEEF, 2'b11);
    step();
    check("zw_stb", 32'(stb_out), 32'd1);
    check("zw_adr", 32'(adr_out), 32'h0010);
    check("zw_dat", 32'(data_out), 32'hBEEF);
    req_valid = 1'b0; akn_in = 1'b1;
    step();
    akn_in = 1'b0;
    check("zw_stb_low", 32'(stb_out), 32'd0);
    check("zw_rv",  32'(resp_valid), 32'd1);
    check("zw_err", 32'(resp_err), 32'd0);
    check("zw_rd",  32'(resp_data), 32'd0);
    step();
    check("zw_rv_pulse", 32'(resp_valid), 32'd0);

    // Read with three wait states
    drive_req(1'b0, 16'h0020, 16'h5555, 2'b11);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rd3_stb", 32'(stb_out), 32'd1);
      check("rd3_ready", 32'(req_ready), 32'd0);
      if (k == 3) begin akn_in = 1'b1; data_in = 16'h1234; end
      step();
    end
    akn_in = 1'b0; data_in = 16'h0000;
    check("rd3_stb_low", 32'(stb_out), 32'd0);
    check("rd3_rv", 32'(resp_valid), 32'd1);
    check("rd3_rd", 32'(resp_data), 32'h1234);

    // Back-to-back with req_valid held
    drive_req(1'b1, 16'h0100, 16'hAAAA, 2'b01);
    step();
    check("b2b_stb1", 32'(stb_out), 32'd1);
    drive_req(1'b1, 16'h0200, 16'hBBBB, 2'b10);
    akn_in = 1'b1;
    step();
    akn_in = 1'b0;
    check("b2b_rv1", 32'(resp_valid), 32'd1);
    check("b2b_gap", 32'(stb_out), 32'd0);
    check("b2b_ready", 32'(req_ready), 32'd1);
    step();
    check("b2b_stb2", 32'(stb_out), 32'd1);
    check("b2b_adr2", 32'(adr_out), 32'h0200);
    req_valid = 1'b0; akn_in = 1'b1;
    step();
    akn_in = 1'b0;
    check("b2b_rv2", 32'(resp_valid), 32'd1);

    // Error precedence on a read
    drive_req(1'b0, 16'h0300, 16'h0, 2'b11);
    step();
    req_valid = 1'b0; akn_in = 1'b1; err_in = 1'b1; data_in = 16'hFFFF;
    step();
    akn_in = 1'b0; err_in = 1'b0; data_in = 16'h0000;
    check("ep_rv",  32'(resp_valid), 32'd1);
    check("ep_err", 32'(resp_err), 32'd1);
    check("ep_rd",  32'(resp_data), 32'd0);

    // Reset mid-cycle
    drive_req(1'b0, 16'h0400, 16'h0, 2'b11);
    step();
    req_valid = 1'b0;
    check("rm_stb_before", 32'(stb_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rm_stb_async", 32'(stb_out), 32'd0);
    check("rm_cyc_async", 32'(cyc_out), 32'd0);
    #1 rst = 1'b0;
    step();
    check("rm_no_rv", 32'(resp_valid), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd1);

`ifdef WB_TIMEOUT_EN
    // Silent slave: watchdog fires after TIMEOUT strobe cycles
    drive_req(1'b0, 16'h0500, 16'h0, 2'b11);
    step();
    req_valid = 1'b0;
    n = 0;
    while (stb_out && n < 20) begin n++; step(); end
    check("to_len", 32'(n), 32'd4);
    check("to_rv",  32'(resp_valid), 32'd1);
    check("to_err", 32'(resp_err), 32'd1);
    // Ack in the 4th cycle beats the watchdog
    drive_req(1'b0, 16'h0600, 16'h0, 2'b11);
    step();
    req_valid = 1'b0;
    n = 0;
    while (stb_out && n < 20) begin
      n++;
      if (n == 4) begin akn_in = 1'b1; data_in = 16'h4321; end
      step();
    end
    akn_in = 1'b0; data_in = 16'h0000;
    check("toa_len", 32'(n), 32'd4);
    check("toa_rv",  32'(resp_valid), 32'd1);
    check("toa_err", 32'(resp_err), 32'd0);
    check("toa_rd",  32'(resp_data), 32'h4321);
`else
    n = 0;
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step();
      req_valid = ($urandom_range(0, 9) < 6);
      req_we    = 1'($urandom);
      req_adr   = 16'($urandom);
      req_data  = 16'($urandom);
      req_sel   = 2'($urandom);
      akn_in    = ($urandom_range(0, 9) < 3);
      err_in    = ($urandom_range(0, 19) == 0);
      data_in   = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    step();
    req_valid = 1'b0; akn_in = 1'b0; err_in = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Parametrised Wishbone master that turns single CPU load/store requests into Wishbone classic cycles, replacing hand-driven bus signals with a registered, handshaked engine. It sits between the CPU core's memory port and the Wishbone interconnect. It is generic in address width, data width and byte-select width. It adds an error path and an optional bus watchdog.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width; must be a multiple of 8
- SEL_W, DATA_W/8, byte-select width
- TIMEOUT, 255, watchdog limit in cycles; only used with WB_TIMEOUT_EN; must be ≥1

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  bridge accepts a request this cycle
- req_we  in  1  0 = read, 1 = write
- req_adr  in  ADDR_W  request address
- req_data  in  DATA_W  write data
- req_sel  in  SEL_W  byte enables
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  completion was an error or timeout; valid with resp_valid
- adr_out  out  ADDR_W  Wishbone address
- data_out  out  DATA_W  Wishbone write data
- data_in  in  DATA_W  Wishbone read data
- we_out  out  1  Wishbone write enable
- sel_out  out  SEL_W  Wishbone byte select
- stb_out  out  1  Wishbone strobe
- cyc_out  out  1  Wishbone cycle
- akn_in  in  1  Wishbone acknowledge
- err_in  in  1  Wishbone error termination

## Operation
- FSM states: IDLE and BUS. The reset state is IDLE.
- IDLE:
  - req_ready = 1.
  - If req_valid = 1, latch req_we, req_adr, req_data and req_sel into output registers, then go to BUS.
- BUS:
  - stb_out = cyc_out = 1.
  - Bus outputs hold their latched values; req_* inputs are ignored; req_ready = 0.
- Termination, sampled at a rising edge while in BUS:
  - err_in = 1: go to IDLE, resp_valid = 1, resp_err = 1, resp_data = 0.
  - Else akn_in = 1: go to IDLE, resp_valid = 1, resp_err = 0.
    - Read: resp_data = data_in.
    - Write: resp_data = 0.
  - If err_in and akn_in are high in the same cycle, err_in wins.
- akn_in and err_in sampled in IDLE are ignored and produce no response.
- resp_valid is a one-cycle pulse with no backpressure. The CPU must capture it.
- When stb_out is low, we_out, sel_out, adr_out and data_out keep their last values. Slaves must qualify on stb_out.
- resp_data and resp_err hold their last values between pulses.

## Timing
- Reset values: req_ready = 1; resp_valid = 0, resp_err = 0, resp_data = 0; stb_out = cyc_out = 0, we_out = 0; adr_out, data_out and sel_out are all 0.
- Accept at edge N puts stb_out and cyc_out high from edge N.
- With a zero-wait slave (akn_in high during cycle N), resp_valid is high from edge N+1, and stb_out and cyc_out are low from edge N+1.
- Each wait state the slave adds delays termination by one cycle.
- req_ready is high in the same cycle as resp_valid. A new request can be accepted at edge N+1, giving a throughput of 2 cycles per transfer.
- rst asserted mid-cycle drops stb_out and cyc_out immediately (asynchronously) and returns the FSM to IDLE. No response is generated for the aborted transfer.

## Configuration
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to BUS and increments every BUS cycle.
  - When it reaches TIMEOUT with no termination, the cycle aborts: stb_out and cyc_out drop, and the FSM goes to IDLE with resp_valid = 1, resp_err = 1 and resp_data = 0.
  - akn_in or err_in arriving in the cycle the counter reaches TIMEOUT takes precedence over the timeout.
- Undefined:
  - No counter is present.
  - BUS waits indefinitely for akn_in or err_in.

## Test plan
- Zero-wait write: req adr = 0x0010, data = 0xBEEF, sel = 2'b11, we = 1; slave acks immediately. Required: stb_out high exactly 1 cycle with adr_out = 0x0010 and data_out = 0xBEEF; resp_valid pulses 1 cycle with resp_err = 0 and resp_data = 0.
- Read with 3 wait states: slave returns data_in = 0x1234 with akn_in in the 4th stb cycle. Required: stb_out high for 4 cycles; resp_data = 0x1234; req_ready = 0 throughout BUS.
- Back-to-back: req_valid held high with two requests. Required: the second stb_out rises at the edge after the first resp_valid, i.e. 2-cycle spacing.
- Error precedence: err_in and akn_in high together on a read. Required: resp_err = 1 and resp_data = 0.
- Reset mid-cycle: rst pulses while stb_out = 1. Required: stb_out and cyc_out go to 0 before the next clk edge; no resp_valid; req_ready = 1 after reset.
- WB_TIMEOUT_EN with TIMEOUT = 4: slave never acks. Required: stb_out high for 4 cycles, then resp_valid with resp_err = 1. Repeat with akn_in in the 4th cycle. Required: resp_err = 0.
